spi_regbank_burst: RTL
======================

// Module: spi_regbank_burst
// PURPOSE
//   Parametrised SPI-slave register bank; successor to the fixed 8x8 cfg/status SPI wrapper.
//   Adds all four SPI modes latched per frame, independent cfg/status counts, burst transfers
//   with address auto-increment, and per-write strobes.
//   Sits behind the top-level 2-stage synchronisers; all SPI inputs are already in clk domain.
// PARAMETERS
//   NUM_CFG     8       number of read/write config registers (1..64)
//   NUM_STATUS  8       number of read-only status registers (1..64); independent of NUM_CFG
//   REG_WIDTH   8       bits per register (8..32)
//   CFG_RESET   '0      flat NUM_CFG*REG_WIDTH reset image for config_regs
// PORTS
//   clk            in   1                     system clock
//   rst            in   1                     synchronous, active-high reset
//   ena            in   1                     clock enable; when 0 all state holds
//   mode           in   2                     {cpol,cpha}, synchronised
//   spi_cs_n       in   1                     chip select, active low, synchronised
//   spi_clk        in   1                     SCLK, synchronised
//   spi_mosi       in   1                     MOSI, synchronised
//   spi_miso       out  1                     MISO data
//   spi_miso_oe    out  1                     1 while frame active (cs_n low)
//   config_regs    out  NUM_CFG*REG_WIDTH     config register file, reg n at [n*W +: W]
//   status_regs    in   NUM_STATUS*REG_WIDTH  status inputs, sampled at load time
//   cfg_wr_stb     out  1                     1-cycle pulse when a config reg is written
//   cfg_wr_addr    out  7                     address of that write; valid with cfg_wr_stb
//   busy           out  1                     FSM not in IDLE
// BEHAVIOUR
//   Reset: config_regs=CFG_RESET; spi_miso=0, spi_miso_oe=0, cfg_wr_stb=0, cfg_wr_addr=0,
//     busy=0; FSM=IDLE; shift regs and bit counters cleared.
//   Edge detect: prev-sample flop on spi_clk. sample_edge = rising if cpol==cpha, else falling;
//     shift_edge = the opposite edge. Edges are ignored while cs_n is high.
//   mode is latched on the cs_n falling edge; mode changes mid-frame have no effect.
//   Frame: 8-bit command, MSB first: [7]=1 write / 0 read, [6:0]=start address A.
//     Data follows in REG_WIDTH-bit words, MSB first, unbounded burst while cs_n is low.
//   Address map: 0..NUM_CFG-1 = cfg (R/W); NUM_CFG..NUM_CFG+NUM_STATUS-1 = status (RO);
//     other addresses: write ignored (no stb), read returns 0.
//   Auto-increment: after each completed word addr=addr+1, 7-bit wrap (127 -> 0).
//   FSM: IDLE -(cs_n fall)-> CMD -(8th sample_edge)-> WDATA | RDATA.
//     Any state -(cs_n rise)-> IDLE on the same cycle. Abort takes priority over a coincident edge.
//   WDATA: on REG_WIDTH-th sample_edge, next clk: target cfg reg updated, cfg_wr_stb=1 for
//     exactly one clk, cfg_wr_addr=addr. Write protection on status addresses yields no stb.
//   RDATA: on first shift_edge after a word boundary, load shifter from current addr and drive
//     MSB on spi_miso; each later shift_edge shifts. Status value is a snapshot at load.
//     Mode 0/1 timing is uniform: MSB appears on the shift edge after the 8th command bit.
//   spi_miso=0 outside RDATA. spi_miso_oe = frame active, registered, 1 clk after cs_n fall.
//   Partial words at cs_n rise are discarded; no write, no stb.
//   rst mid-frame: immediate return to reset state; a frame in progress is lost.
//   ena=0: all state holds, including edge-detect history.
// STRUCTURE
//   spi_regbank_pkg: state_e {IDLE,CMD,WDATA,RDATA}; CMD_W=8, ADDR_W=7, CMD_RW_BIT=7.
//   Sub-module spi_sclk_edge: edge detect plus mode latch; outputs sample_edge and shift_edge.
//   Top: FSM, bit counter ($clog2(REG_WIDTH)+1), address counter, shifters, register file.
// TESTING
//   Mode 0, W=8: write cmd 0x81, data 0x3C,0x5A -> cfg[1]=0x3C, cfg[2]=0x5A; two stbs, addr 1,2.
//   Modes 1,2,3 in turn: read cmd 0x08, status[0]=0xCA -> MISO returns 0xCA in every mode.
//   Burst read starting at 0x07 with NUM_CFG=8 -> cfg[7], then status[0], status[1] in order.
//   Write to 0x7F, then 0x00 -> wrap; 0x7F out of range (no stb); cfg[0] written.
//   cs_n rise after 5 data bits of write to 0x83 -> cfg[3] unchanged, no stb, busy=0 next clk.
//   Assert rst mid-burst -> config_regs=CFG_RESET, miso_oe=0; next frame works normally.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the burst-capable SPI register bank.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam int CMD_W      = 8;
  localparam int ADDR_W     = 7;
  localparam int CMD_RW_BIT = 7;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return (mode[1] == mode[0]);
  endfunction

endpackage

// File: rtl/spi_sclk_edge.sv
// SCLK edge classifier: latches the SPI mode at frame start and reports sample/shift edges.
module spi_sclk_edge
  import spi_regbank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] mode,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  output logic       sample_edge,
  output logic       shift_edge,
  output logic       cs_fall
);

  logic       sclk_q;
  logic       cs_n_q;
  logic [1:0] mode_q;
  logic       rise_s;
  logic       fall_s;

  // History flops; cs_n_q resets low so a chip select held low through reset never opens a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b0;
      mode_q <= 2'b00;
    end else if (ena) begin
      sclk_q <= spi_clk;
      cs_n_q <= spi_cs_n;
      if (cs_fall) begin
        mode_q <= mode;
      end else begin
        mode_q <= mode_q;
      end
    end else begin
      sclk_q <= sclk_q;
      cs_n_q <= cs_n_q;
      mode_q <= mode_q;
    end
  end

  always_comb begin
    rise_s      = spi_clk & ~sclk_q;
    fall_s      = ~spi_clk & sclk_q;
    cs_fall     = cs_n_q & ~spi_cs_n;
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    if (!spi_cs_n) begin
      sample_edge = sample_on_rise(mode_q) ? rise_s : fall_s;
      shift_edge  = sample_on_rise(mode_q) ? fall_s : rise_s;
    end else begin
      sample_edge = 1'b0;
      shift_edge  = 1'b0;
    end
  end

endmodule

// File: rtl/spi_regbank_burst.sv
// SPI-slave register bank: R/W config regs, RO status regs, burst access with address
// auto-increment and a one-cycle strobe per config write.
module spi_regbank_burst
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic                            spi_miso_oe,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            cfg_wr_stb,
  output logic [ADDR_W-1:0]               cfg_wr_addr,
  output logic                            busy
);

  localparam int CNT_W = $clog2(REG_WIDTH) + 1;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [REG_WIDTH-2:0]           rx_q, rx_d;
  logic [REG_WIDTH-1:0]           tx_q, tx_d;
  logic                           load_pend_q, load_pend_d;
  logic [NUM_CFG*REG_WIDTH-1:0]   cfg_q, cfg_d;
  logic                           stb_q, stb_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
  logic                           active_q, active_d;

  logic                           sample_edge_s;
  logic                           shift_edge_s;
  logic                           cs_fall_s;
  logic [REG_WIDTH-1:0]           word_in_s;
  logic [REG_WIDTH-1:0]           rd_word_s;
  int                             addr_int_s;

  spi_sclk_edge u_edge (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mode        (mode),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .sample_edge (sample_edge_s),
    .shift_edge  (shift_edge_s),
    .cs_fall     (cs_fall_s)
  );

  assign word_in_s  = {rx_q, spi_mosi};
  assign addr_int_s = int'(addr_q);

  // Read mux; status is captured into the shifter only at load, giving a per-word snapshot.
  always_comb begin
    rd_word_s = '0;
    if (addr_int_s < NUM_CFG) begin
      rd_word_s = cfg_q[addr_int_s*REG_WIDTH +: REG_WIDTH];
    end else if (addr_int_s < NUM_CFG + NUM_STATUS) begin
      rd_word_s = status_regs[(addr_int_s-NUM_CFG)*REG_WIDTH +: REG_WIDTH];
    end else begin
      rd_word_s = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    load_pend_d = load_pend_q;
    cfg_d       = cfg_q;
    stb_d       = 1'b0;
    wr_addr_d   = wr_addr_q;

    // Chip-select release aborts the frame before any coincident edge is considered.
    if (spi_cs_n) begin
      state_d     = IDLE;
      cnt_d       = '0;
      rx_d        = '0;
      tx_d        = '0;
      load_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_s) begin
            state_d = CMD;
            cnt_d   = '0;
            rx_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (sample_edge_s) begin
            if (cnt_q == CNT_W'(CMD_W-1)) begin
              addr_d      = word_in_s[ADDR_W-1:0];
              state_d     = word_in_s[CMD_RW_BIT] ? WDATA : RDATA;
              cnt_d       = '0;
              rx_d        = '0;
              load_pend_d = 1'b1;
            end else begin
              rx_d  = word_in_s[REG_WIDTH-2:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        WDATA: begin
          if (sample_edge_s) begin
            if (cnt_q == CNT_W'(REG_WIDTH-1)) begin
              cnt_d  = '0;
              rx_d   = '0;
              addr_d = addr_q + ADDR_W'(1);
              if (addr_int_s < NUM_CFG) begin
                cfg_d[addr_int_s*REG_WIDTH +: REG_WIDTH] = word_in_s;
                stb_d     = 1'b1;
                wr_addr_d = addr_q;
              end else begin
                stb_d = 1'b0;
              end
            end else begin
              rx_d  = word_in_s[REG_WIDTH-2:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        RDATA: begin
          if (sample_edge_s) begin
            if (cnt_q == CNT_W'(REG_WIDTH-1)) begin
              cnt_d       = '0;
              addr_d      = addr_q + ADDR_W'(1);
              load_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (shift_edge_s) begin
            if (load_pend_q) begin
              tx_d        = rd_word_s;
              load_pend_d = 1'b0;
            end else begin
              tx_d = {tx_q[REG_WIDTH-2:0], 1'b0};
            end
          end else begin
            tx_d = tx_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    active_d = (state_d != IDLE);
  end

  // State register; ena freezes everything, including the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      load_pend_q <= 1'b0;
      cfg_q       <= CFG_RESET;
      stb_q       <= 1'b0;
      wr_addr_q   <= '0;
      active_q    <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      load_pend_q <= load_pend_d;
      cfg_q       <= cfg_d;
      stb_q       <= stb_d;
      wr_addr_q   <= wr_addr_d;
      active_q    <= active_d;
    end else begin
      state_q     <= state_q;
      cnt_q       <= cnt_q;
      addr_q      <= addr_q;
      rx_q        <= rx_q;
      tx_q        <= tx_q;
      load_pend_q <= load_pend_q;
      cfg_q       <= cfg_q;
      stb_q       <= stb_q;
      wr_addr_q   <= wr_addr_q;
      active_q    <= active_q;
    end
  end

  assign spi_miso    = tx_q[REG_WIDTH-1];
  assign spi_miso_oe = active_q;
  assign busy        = active_q;
  assign config_regs = cfg_q;
  assign cfg_wr_stb  = stb_q;
  assign cfg_wr_addr = wr_addr_q;

endmodule
